// File: rtl/gyro_bias_calibrator_pkg.sv
// -----------------------------------------------------------------------------
// gyro_bias_calibrator_pkg
// Shared definitions for the gyro bias calibrator: controller state encoding,
// default sample width / calibration length, and the output saturation limits.
// No ports (package).
// -----------------------------------------------------------------------------
package gyro_bias_calibrator_pkg;

  typedef enum logic [1:0] {
    ST_PASS  = 2'd0,
    ST_CALIB = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam int DATA_W_DEF     = 16;
  localparam int CALIB_LOG2_DEF = 6;

  // Largest / smallest representable signed value for a given sample width.
  function automatic int sat_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int w);
    return -(1 << (w - 1));
  endfunction

  // Limits for the default 16-bit sample width: [-32768, 32767].
  localparam int SAT_MAX = sat_max(DATA_W_DEF);
  localparam int SAT_MIN = sat_min(DATA_W_DEF);

endpackage

// File: rtl/gyro_bias_calibrator_axis_bias.sv
// -----------------------------------------------------------------------------
// gyro_axis_bias
// One gyro axis: calibration accumulator, bias register and the registered
// bias-subtract / saturate output stage. Sequencing comes from the top level.
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   acc_clear    : clear the accumulator (calibration (re)start)
//   acc_en       : add sample_in (sign-extended) into the accumulator
//   bias_load    : last calibration sample; bias <= (acc + sample_in) >>> CALIB_LOG2
//   use_bias     : subtract the bias (RUN); otherwise the bias applied is 0
//   out_load     : capture sat(sample_in - bias) into sample_out
//   sample_in    : signed raw sample
//   sample_out   : signed registered corrected sample
//   bias_out     : current signed bias estimate
// -----------------------------------------------------------------------------
module gyro_axis_bias
  import gyro_bias_calibrator_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int CALIB_LOG2 = CALIB_LOG2_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     acc_clear,
  input  logic                     acc_en,
  input  logic                     bias_load,
  input  logic                     use_bias,
  input  logic                     out_load,
  input  logic signed [DATA_W-1:0] sample_in,
  output logic signed [DATA_W-1:0] sample_out,
  output logic signed [DATA_W-1:0] bias_out
);

  localparam int ACC_W  = DATA_W + CALIB_LOG2;
  localparam int DIFF_W = DATA_W + 1;

  localparam logic signed [DIFF_W-1:0] LIM_HI = DIFF_W'(sat_max(DATA_W));
  localparam logic signed [DIFF_W-1:0] LIM_LO = DIFF_W'(sat_min(DATA_W));

  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [DATA_W-1:0] bias;
  logic signed [DATA_W-1:0] bias_eff;
  logic signed [DIFF_W-1:0] diff;
  logic signed [DATA_W-1:0] sat_val;

  assign acc_sum  = acc + {{CALIB_LOG2{sample_in[DATA_W-1]}}, sample_in};
  assign bias_eff = use_bias ? bias : '0;
  assign diff     = {sample_in[DATA_W-1], sample_in} - {bias_eff[DATA_W-1], bias_eff};
  assign bias_out = bias;

  always_comb begin
    sat_val = diff[DATA_W-1:0];
    if (diff > LIM_HI) begin
      sat_val = LIM_HI[DATA_W-1:0];
    end else if (diff < LIM_LO) begin
      sat_val = LIM_LO[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      bias       <= '0;
      sample_out <= '0;
    end else begin
      if (acc_clear) begin
        acc <= '0;
      end else if (acc_en) begin
        acc <= acc_sum;
      end
      // Upper DATA_W bits of the sum are exactly sum >>> CALIB_LOG2, i.e. the
      // mean rounded toward minus infinity; the final sample is folded in here.
      if (bias_load) begin
        bias <= acc_sum[ACC_W-1:CALIB_LOG2];
      end
      if (out_load) begin
        sample_out <= sat_val;
      end
    end
  end

endmodule

// File: rtl/gyro_bias_calibrator.sv
// -----------------------------------------------------------------------------
// gyro_bias_calibrator
// Averages 2^CALIB_LOG2 gyro samples per axis into a bias estimate, then
// forwards bias-corrected, saturated samples with a one-deep valid/ready
// output register. Before the first calibration samples pass through.
//
// Ports
//   clk, rst_n              : clock, asynchronous active-low reset
//   in_valid                : one-cycle strobe, x/y/z_in hold a complete triple
//   x_in, y_in, z_in        : signed raw samples
//   calib_start             : pulse, (re)start calibration from any state
//   x_out, y_out, z_out     : signed corrected samples (registered)
//   out_valid, out_ready    : output handshake
//   bias_x, bias_y, bias_z  : current bias estimates
//   calib_busy              : calibration in progress
//   calib_done              : sticky, a calibration has completed
//   overrun                 : sticky, a sample was dropped (cleared by reset only)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_PASS  | after reset, samples forwarded with bias 0
// ST_CALIB | accumulating samples, no output produced
// ST_RUN   | samples forwarded as sat(in - bias)
// -----------------------------------------------------------------------------
module gyro_bias_calibrator
  import gyro_bias_calibrator_pkg::*;
#(
  parameter int CALIB_LOG2 = CALIB_LOG2_DEF,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic signed [DATA_W-1:0] y_in,
  input  logic signed [DATA_W-1:0] z_in,
  input  logic                     calib_start,
  output logic signed [DATA_W-1:0] x_out,
  output logic signed [DATA_W-1:0] y_out,
  output logic signed [DATA_W-1:0] z_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] bias_x,
  output logic signed [DATA_W-1:0] bias_y,
  output logic signed [DATA_W-1:0] bias_z,
  output logic                     calib_busy,
  output logic                     calib_done,
  output logic                     overrun
);

  localparam logic [CALIB_LOG2-1:0] COUNT_LAST = '1;

  state_t                state;
  logic [CALIB_LOG2-1:0] count;

  logic accept;
  logic calib_take;
  logic calib_last;
  logic fwd;
  logic out_load;
  logic drop;
  logic use_bias;

  // calib_start takes priority over a coincident sample, which is discarded.
  assign accept     = in_valid & ~calib_start;
  assign calib_take = accept & (state == ST_CALIB);
  assign calib_last = calib_take & (count == COUNT_LAST);
  assign fwd        = accept & (state != ST_CALIB);
  // A pending output being accepted this cycle frees the register for a new one.
  assign out_load   = fwd & (~out_valid | out_ready);
  assign drop       = fwd & out_valid & ~out_ready;
  assign use_bias   = (state == ST_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_PASS;
      count      <= '0;
      out_valid  <= 1'b0;
      calib_busy <= 1'b0;
      calib_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (drop) begin
        overrun <= 1'b1;
      end
      if (calib_start) begin
        state      <= ST_CALIB;
        count      <= '0;
        out_valid  <= 1'b0;
        calib_busy <= 1'b1;
      end else begin
        case (state)
          ST_CALIB: begin
            out_valid <= 1'b0;
            if (calib_take) begin
              count <= count + 1'b1;
            end
            if (calib_last) begin
              state      <= ST_RUN;
              calib_busy <= 1'b0;
              calib_done <= 1'b1;
            end
          end
          default: begin
            if (out_load) begin
              out_valid <= 1'b1;
            end else if (out_ready) begin
              out_valid <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  gyro_axis_bias #(.DATA_W(DATA_W), .CALIB_LOG2(CALIB_LOG2)) u_axis_x (
    .clk        (clk),
    .rst_n      (rst_n),
    .acc_clear  (calib_start),
    .acc_en     (calib_take),
    .bias_load  (calib_last),
    .use_bias   (use_bias),
    .out_load   (out_load),
    .sample_in  (x_in),
    .sample_out (x_out),
    .bias_out   (bias_x)
  );

  gyro_axis_bias #(.DATA_W(DATA_W), .CALIB_LOG2(CALIB_LOG2)) u_axis_y (
    .clk        (clk),
    .rst_n      (rst_n),
    .acc_clear  (calib_start),
    .acc_en     (calib_take),
    .bias_load  (calib_last),
    .use_bias   (use_bias),
    .out_load   (out_load),
    .sample_in  (y_in),
    .sample_out (y_out),
    .bias_out   (bias_y)
  );

  gyro_axis_bias #(.DATA_W(DATA_W), .CALIB_LOG2(CALIB_LOG2)) u_axis_z (
    .clk        (clk),
    .rst_n      (rst_n),
    .acc_clear  (calib_start),
    .acc_en     (calib_take),
    .bias_load  (calib_last),
    .use_bias   (use_bias),
    .out_load   (out_load),
    .sample_in  (z_in),
    .sample_out (z_out),
    .bias_out   (bias_z)
  );

endmodule

// File: tb/tb_gyro_bias_calibrator.sv
// -----------------------------------------------------------------------------
// tb_gyro_bias_calibrator
// Directed sequence with random sample values; expected biases are plain
// floor means of the fed samples and outputs are clamp(in - bias).
// -----------------------------------------------------------------------------
module tb_gyro_bias_calibrator;

  localparam int DATA_W     = 16;
  localparam int CALIB_LOG2 = 6;
  localparam int N          = 1 << CALIB_LOG2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     in_valid;
  logic signed [DATA_W-1:0] x_in, y_in, z_in;
  logic                     calib_start;
  logic signed [DATA_W-1:0] x_out, y_out, z_out;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] bias_x, bias_y, bias_z;
  logic                     calib_busy;
  logic                     calib_done;
  logic                     overrun;

  int     n_cmp = 0;
  int     n_bad = 0;
  longint sum[3];
  int     bm[3];

  always #5 clk = ~clk;

  gyro_bias_calibrator #(.CALIB_LOG2(CALIB_LOG2), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .x_in        (x_in),
    .y_in        (y_in),
    .z_in        (z_in),
    .calib_start (calib_start),
    .x_out       (x_out),
    .y_out       (y_out),
    .z_out       (z_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .bias_x      (bias_x),
    .bias_y      (bias_y),
    .bias_z      (bias_z),
    .calib_busy  (calib_busy),
    .calib_done  (calib_done),
    .overrun     (overrun)
  );

  function automatic int rnd();
    return int'($urandom_range(65535, 0)) - 32768;
  endfunction

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int floor_mean(input longint s);
    longint q;
    q = s / N;
    if ((s % N) != 0 && s < 0) q = q - 1;
    return int'(q);
  endfunction

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs; outputs are examined 1 time unit after the edge.
  task automatic step(input bit iv, input int x, input int y, input int z,
                      input bit cs, input bit rdy);
    in_valid    = iv;
    x_in        = 16'(x);
    y_in        = 16'(y);
    z_in        = 16'(z);
    calib_start = cs;
    out_ready   = rdy;
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    calib_start = 1'b0;
  endtask

  task automatic feed(input int cnt, input bit rx, input int fx, input bit ry,
                      input int fy, input bit rz, input int fz);
    int v[3];
    for (int i = 0; i < cnt; i++) begin
      if ($urandom_range(3, 0) == 0) step(1'b0, 0, 0, 0, 1'b0, 1'b1);
      v[0] = rx ? rnd() : fx;
      v[1] = ry ? rnd() : fy;
      v[2] = rz ? rnd() : fz;
      for (int k = 0; k < 3; k++) sum[k] += longint'(v[k]);
      step(1'b1, v[0], v[1], v[2], 1'b0, 1'b1);
      check("calib_no_out_valid", out_valid, 0);
    end
  endtask

  task automatic clear_sums();
    for (int k = 0; k < 3; k++) sum[k] = 0;
  endtask

  task automatic take_bias();
    for (int k = 0; k < 3; k++) bm[k] = floor_mean(sum[k]);
  endtask

  initial begin
    int a, b, c, ax, ay, az;
    rst_n = 1'b0; in_valid = 1'b0; calib_start = 1'b0; out_ready = 1'b1;
    x_in = '0; y_in = '0; z_in = '0;
    bm[0] = 0; bm[1] = 0; bm[2] = 0;
    clear_sums();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_calib_busy", calib_busy, 0);
    check("rst_calib_done", calib_done, 0);
    check("rst_overrun", overrun, 0);
    check("rst_bias_x", bias_x, 0);
    check("rst_x_out", x_out, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Pass-through with bias 0, latency 1
    b = rnd(); c = rnd();
    step(1'b1, 100, b, c, 1'b0, 1'b1);
    check("pass_out_valid", out_valid, 1);
    check("pass_x_out", x_out, 100);
    check("pass_y_out", y_out, b);
    check("pass_z_out", z_out, c);
    check("pass_bias_x", bias_x, 0);
    step(1'b0, 0, 0, 0, 1'b0, 1'b1);
    check("pass_drain", out_valid, 0);
    for (int i = 0; i < 6; i++) begin
      a = rnd(); b = rnd(); c = rnd();
      step(1'b1, a, b, c, 1'b0, 1'b1);
      check("pass_b2b_valid", out_valid, 1);
      check("pass_b2b_x", x_out, a);
      check("pass_b2b_y", y_out, b);
      check("pass_b2b_z", z_out, c);
    end
    step(1'b0, 0, 0, 0, 1'b0, 1'b1);

    // First calibration: constant 10 / -3 / 0
    step(1'b0, 0, 0, 0, 1'b1, 1'b1);
    check("cal1_busy", calib_busy, 1);
    check("cal1_out_valid", out_valid, 0);
    clear_sums();
    feed(N, 1'b0, 10, 1'b0, -3, 1'b0, 0);
    take_bias();
    check("cal1_bias_x", bias_x, bm[0]);
    check("cal1_bias_y", bias_y, bm[1]);
    check("cal1_bias_z", bias_z, bm[2]);
    check("cal1_bias_x_const", bias_x, 10);
    check("cal1_done", calib_done, 1);
    check("cal1_busy_drop", calib_busy, 0);

    // Negative saturation
    b = rnd(); c = rnd();
    step(1'b1, -32768, b, c, 1'b0, 1'b1);
    check("sat_lo_valid", out_valid, 1);
    check("sat_lo_x", x_out, sat16(-32768 - bm[0]));
    check("sat_lo_x_const", x_out, -32768);
    check("sat_lo_y", y_out, sat16(b - bm[1]));
    check("sat_lo_z", z_out, sat16(c - bm[2]));

    // Second calibration: x constant -5, y/z random; old bias held meanwhile
    step(1'b0, 0, 0, 0, 1'b1, 1'b1);
    check("cal2_out_valid", out_valid, 0);
    check("cal2_old_bias_x", bias_x, 10);
    clear_sums();
    feed(N, 1'b0, -5, 1'b1, 0, 1'b1, 0);
    take_bias();
    check("cal2_bias_x", bias_x, -5);
    check("cal2_bias_y", bias_y, bm[1]);
    check("cal2_bias_z", bias_z, bm[2]);

    // Positive saturation
    b = rnd(); c = rnd();
    step(1'b1, 32767, b, c, 1'b0, 1'b1);
    check("sat_hi_x", x_out, 32767);
    check("sat_hi_y", y_out, sat16(b - bm[1]));
    check("sat_hi_z", z_out, sat16(c - bm[2]));
    step(1'b0, 0, 0, 0, 1'b0, 1'b1);
    check("run_drain", out_valid, 0);

    // Back-pressure: hold, drop, replace
    ax = rnd(); ay = rnd(); az = rnd();
    step(1'b1, ax, ay, az, 1'b0, 1'b0);
    check("bp_first_valid", out_valid, 1);
    check("bp_first_x", x_out, sat16(ax - bm[0]));
    check("bp_no_overrun_yet", overrun, 0);
    a = rnd(); b = rnd(); c = rnd();
    step(1'b1, a, b, c, 1'b0, 1'b0);
    check("bp_held_valid", out_valid, 1);
    check("bp_held_x", x_out, sat16(ax - bm[0]));
    check("bp_held_y", y_out, sat16(ay - bm[1]));
    check("bp_held_z", z_out, sat16(az - bm[2]));
    check("bp_overrun", overrun, 1);
    a = rnd(); b = rnd(); c = rnd();
    step(1'b1, a, b, c, 1'b0, 1'b1);
    check("bp_replace_valid", out_valid, 1);
    check("bp_replace_x", x_out, sat16(a - bm[0]));
    check("bp_replace_y", y_out, sat16(b - bm[1]));
    check("bp_replace_z", z_out, sat16(c - bm[2]));
    check("bp_overrun_sticky", overrun, 1);
    step(1'b0, 0, 0, 0, 1'b0, 1'b1);
    check("bp_drain", out_valid, 0);

    // Pending output discarded on calibration entry; restart after 40 samples
    a = rnd();
    step(1'b1, a, 0, 0, 1'b0, 1'b0);
    check("pend_valid", out_valid, 1);
    step(1'b0, 0, 0, 0, 1'b1, 1'b0);
    check("pend_discard", out_valid, 0);
    check("cal3_busy", calib_busy, 1);
    out_ready = 1'b1;
    clear_sums();
    feed(40, 1'b1, 0, 1'b1, 0, 1'b1, 0);
    step(1'b1, 30000, 30000, 30000, 1'b1, 1'b1);
    check("restart_busy", calib_busy, 1);
    clear_sums();
    feed(N - 1, 1'b1, 0, 1'b1, 0, 1'b1, 0);
    check("restart_busy_63", calib_busy, 1);
    check("restart_bias_held_x", bias_x, bm[0]);
    check("restart_bias_held_y", bias_y, bm[1]);
    feed(1, 1'b1, 0, 1'b1, 0, 1'b1, 0);
    take_bias();
    check("restart_bias_x", bias_x, bm[0]);
    check("restart_bias_y", bias_y, bm[1]);
    check("restart_bias_z", bias_z, bm[2]);
    check("restart_busy_drop", calib_busy, 0);
    check("restart_done", calib_done, 1);

    // calib_start with coincident sample, partial calibration, then reset
    step(1'b1, 12345, 12345, 12345, 1'b1, 1'b1);
    check("cal4_busy", calib_busy, 1);
    clear_sums();
    feed(32, 1'b1, 0, 1'b1, 0, 1'b1, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_bias_x", bias_x, 0);
    check("midrst_bias_y", bias_y, 0);
    check("midrst_bias_z", bias_z, 0);
    check("midrst_done", calib_done, 0);
    check("midrst_busy", calib_busy, 0);
    check("midrst_overrun", overrun, 0);
    check("midrst_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    a = rnd(); b = rnd(); c = rnd();
    step(1'b1, a, b, c, 1'b0, 1'b1);
    check("post_rst_pass_valid", out_valid, 1);
    check("post_rst_pass_x", x_out, a);
    check("post_rst_pass_y", y_out, b);
    check("post_rst_pass_z", z_out, c);
    check("post_rst_busy", calib_busy, 0);
    check("post_rst_done", calib_done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
